// File: rtl/pipe_rca_addsub.sv
// pipe_rca_addsub: pipelined ripple-carry adder/subtractor.
// WIDTH bits are split into STAGES slices of SW bits. Each stage adds one slice
// and registers the carry. The unprocessed upper slices of A and the conditioned
// B travel forward alongside the partial result.
// The valid/ready handshake freezes the whole pipe when the output is stalled.
// Optional macro PIPE_RCA_SAT_EN: the final stage saturates signed overflow.
module pipe_rca_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  generate
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipe_rca_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end
  endgenerate

  // Per-stage registers: skewed operands, partial result, carry, valid
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  // Inputs seen by each stage (stage 0 sees the conditioned operands)
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic [WIDTH-1:0]  fin_s;
  logic              ovf_n;
  logic              c_msb;
  logic              advance;

  assign advance   = !v_q[LAST] | out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

  // Stage input selection: subtraction is a + ~b + ~cin
  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub ? ~cin : cin;
    src_s[0] = '0;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
      src_v[k] = v_q[k-1];
    end
  end

  // One slice add per stage, plus overflow/saturation for the final stage
  always_comb begin
    logic [SW:0] sl;
    sl    = '0;
    nxt_c = '0;
    for (int k = 0; k < STAGES; k++) begin
      sl = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]}
         + (SW+1)'(src_c[k]);
      nxt_s[k]             = src_s[k];
      nxt_s[k][k*SW +: SW] = sl[SW-1:0];
      nxt_c[k]             = sl[SW];
    end
    // carry into the MSB recovered from the MSB sum bit
    c_msb = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ nxt_s[LAST][WIDTH-1];
    ovf_n = c_msb ^ nxt_c[LAST];
    fin_s = nxt_s[LAST];
`ifdef PIPE_RCA_SAT_EN
    if (ovf_n) begin
      fin_s = src_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Pipeline registers; everything shifts together on advance, bubbles included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= src_a[k];
        b_q[k] <= src_b[k];
        s_q[k] <= (k == LAST) ? fin_s : nxt_s[k];
      end
      c_q   <= nxt_c;
      v_q   <= src_v;
      ovf_q <= ovf_n;
    end
  end

endmodule

// File: tb/tb_pipe_rca_addsub.sv
// Scoreboard bench for pipe_rca_addsub (WIDTH=32, STAGES=4).
module tb_pipe_rca_addsub;
  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_pop = 0;
  int           last_lat = -1;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W+2:0] prev_out = '0;

  pipe_rca_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: exact integer arithmetic on the operands
  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci, input logic sb, input int acc);
    exp_t   r;
    longint sa, sbv, sr;
    logic [W:0] ua, ub, uc;
    sa  = longint'($signed(aa));
    sbv = longint'($signed(bb));
    ua  = {1'b0, aa};
    ub  = {1'b0, bb};
    uc  = {{W{1'b0}}, ci};
    if (!sb) begin
      sr = sa + sbv + longint'(ci);
      {r.c, r.s} = ua + ub + uc;
    end else begin
      sr  = sa - sbv - longint'(ci);
      r.s = aa - bb - {{(W-1){1'b0}}, ci};
      r.c = (ua >= ub + uc);
    end
    r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef PIPE_RCA_SAT_EN
    if (r.o) r.s = aa[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    r.acc = acc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Input side: every accepted beat pushes its expected result
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) q.push_back(model(a, b, cin, sub, cyc));
  end

  // Output side: pop and compare on every completed output transfer
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {out_valid, cout, ovf, sum}, prev_out);
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got sum %h, required no output", sum);
        end else begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("ovf", ovf, e.o);
          last_sum  = sum;
          last_cout = cout;
          last_ovf  = ovf;
          last_lat  = cyc - e.acc;
          n_pop++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, cout, ovf, sum};
    end
  end

  task automatic send1(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci, input logic sb);
    @(posedge clk); #1;
    a = aa; b = bb; cin = ci; sub = sb; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // carry ripples through every slice boundary
    send1(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_drain("t1");
    chk("t1_sum", last_sum, 32'h0000_0000);
    chk("t1_cout", last_cout, 1);
    chk("t1_ovf", last_ovf, 0);
    chk("t1_latency", last_lat, S);

    send1(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_drain("t2");
`ifdef PIPE_RCA_SAT_EN
    chk("t2_sum", last_sum, 32'h7FFF_FFFF);
`else
    chk("t2_sum", last_sum, 32'h8000_0000);
`endif
    chk("t2_cout", last_cout, 0);
    chk("t2_ovf", last_ovf, 1);

    send1(32'd5, 32'd7, 1'b0, 1'b1);
    wait_drain("t3a");
    chk("t3a_sum", last_sum, 32'hFFFF_FFFE);
    chk("t3a_cout", last_cout, 0);
    chk("t3a_ovf", last_ovf, 0);

    send1(32'd7, 32'd5, 1'b1, 1'b1);
    wait_drain("t3b");
    chk("t3b_sum", last_sum, 32'h0000_0001);
    chk("t3b_cout", last_cout, 1);
    chk("t3b_ovf", last_ovf, 0);

    send1(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    wait_drain("t3c");
    chk("t3c_ovf", last_ovf, 1);
    chk("t3c_cout", last_cout, 1);

    // back-to-back stream with a downstream stall
    begin
      int   i;
      int   pop0;
      logic saw;
      i = 0; pop0 = n_pop; saw = 1'b0;
      for (int t = 0; t < 60 && i < 8; t++) begin
        @(posedge clk); #1;
        out_ready = !(t >= 6 && t <= 9);
        in_valid = 1'b1; a = W'(i); b = W'(i); cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        if (out_valid && !in_ready) saw = 1'b1;
        if (in_valid && in_ready) i++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      wait_drain("t4");
      chk("t4_count", n_pop - pop0, 8);
      chk("t4_last_sum", last_sum, 32'd14);
      chk("t4_in_ready_dropped", saw, 1);
    end

    // reset with beats in flight
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("t5_pre_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_sum", sum, 0);
    chk("t5_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("t5_no_stale", out_valid, 0);
    send1(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    wait_drain("t5");
    chk("t5_sum_after", last_sum, 32'h2345_678A);
    chk("t5_latency", last_lat, S);

    // random traffic with random back-pressure
    begin
      int n;
      n = 0;
      for (int t = 0; t < 60000 && n < 10000; t++) begin
        @(posedge clk); #1;
        in_valid  = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(3) != 0);
        case ($urandom_range(7))
          0: a = 32'h7FFF_FFFF;
          1: a = 32'h8000_0000;
          2: a = 32'hFFFF_FFFF;
          default: a = $urandom;
        endcase
        case ($urandom_range(7))
          0: b = 32'h0000_0000;
          1: b = 32'hFFFF_FFFF;
          2: b = 32'h8000_0000;
          default: b = $urandom;
        endcase
        cin = 1'($urandom);
        sub = 1'($urandom);
        @(negedge clk);
        if (in_valid && in_ready) n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      chk("t6_beats", n, 10000);
      wait_drain("t6");
    end

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
